// File: rtl/blocpu_loader.sv
// blocpu_loader: receives a length-prefixed instruction image from a byte-stream host,
// writes it into the core's programming port, then resets and starts the core and
// watches until it halts.
// Optional feature: define BLOCPU_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the image; a mismatch ends the session in error before the core is touched.
// Instruction words are sent as two bytes (high byte first), so INSTRUCTION_WIDTH must
// lie in 9..16.
module blocpu_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 12,
    parameter int unsigned ADDRESS_WIDTH     = 16,
    parameter int unsigned RUN_TIMEOUT       = 16
) (
    input  logic                         clock,
    input  logic                         in_reset,
    input  logic                         in_start,
    input  logic [7:0]                   in_byte,
    input  logic                         in_byte_valid,
    output logic                         out_byte_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
    output logic                         out_instruction_write,
    output logic                         out_core_reset,
    output logic                         out_core_running,
    input  logic                         in_core_running,
    output logic                         out_busy,
    output logic                         out_done,
    output logic                         out_error
);

    // Bits of the instruction carried by the high byte; the rest of that byte must be 0.
    localparam int unsigned HiWidth    = INSTRUCTION_WIDTH - 8;
    localparam int unsigned TimerWidth = $clog2(RUN_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StLenHi   = 4'd1,
        StLenLo   = 4'd2,
        StInstHi  = 4'd3,
        StInstLo  = 4'd4,
        StWrHi    = 4'd5,
        StWrLo    = 4'd6,
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        StCheck   = 4'd7,
`endif
        StCoreRst = 4'd8,
        StGap     = 4'd9,
        StStart   = 4'd10,
        StRun     = 4'd11,
        StDone    = 4'd12,
        StError   = 4'd13
    } state_e;

    // Where the session goes once the last instruction is written (or N=0).
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    localparam state_e StAfterLoad = StCheck;
`else
    localparam state_e StAfterLoad = StCoreRst;
`endif

    state_e                       state_q, state_d;
    logic                         start_prev_q;
    logic [7:0]                   len_hi_q, len_hi_d;
    logic [15:0]                  count_q, count_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [HiWidth-1:0]           inst_hi_q, inst_hi_d;
    logic [INSTRUCTION_WIDTH-1:0] inst_q, inst_d;
    logic [TimerWidth-1:0]        timer_q, timer_d;
    logic [1:0]                   sync_q;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    logic [7:0]                   csum_q, csum_d;
`endif

    logic start_rise;
    logic xfer;
    logic core_running_sync;
    logic ready_d, write_d, core_reset_d, core_running_d, busy_d, done_d, error_d;

    assign start_rise        = in_start & ~start_prev_q;
    assign xfer              = in_byte_valid & out_byte_ready;
    assign core_running_sync = sync_q[1];

    assign out_instruction         = inst_q;
    assign out_instruction_address = addr_q;

    // Two-flop synchronizer for the core's running status and start-edge history.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            sync_q       <= 2'b00;
            // A start held high across reset is not a new request.
            start_prev_q <= 1'b1;
        end else begin
            sync_q       <= {sync_q[0], in_core_running};
            start_prev_q <= in_start;
        end
    end

    // Session state, counters and captured instruction data.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= StIdle;
            len_hi_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            inst_hi_q <= '0;
            inst_q    <= '0;
            timer_q   <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            inst_hi_q <= inst_hi_d;
            inst_q    <= inst_d;
            timer_q   <= timer_d;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next-state logic: header capture, instruction assembly, write sequencing, core control.
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        count_d   = count_q;
        addr_d    = addr_q;
        inst_hi_d = inst_hi_q;
        inst_d    = inst_q;
        timer_d   = timer_q;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_rise) begin
                    state_d = StLenHi;
                    count_d = '0;
                    addr_d  = '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_hi_d = in_byte;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    count_d = {len_hi_q, in_byte};
                    addr_d  = '0;
                    state_d = ({len_hi_q, in_byte} == 16'd0) ? StAfterLoad : StInstHi;
                end
            end
            StInstHi: begin
                if (xfer) begin
                    if ((in_byte >> HiWidth) != 8'd0) begin
                        state_d = StError;
                    end else begin
                        inst_hi_d = in_byte[HiWidth-1:0];
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                        csum_d    = csum_q ^ in_byte;
`endif
                        state_d   = StInstLo;
                    end
                end
            end
            StInstLo: begin
                if (xfer) begin
                    inst_d  = {inst_hi_q, in_byte};
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_byte;
`endif
                    state_d = StWrHi;
                end
            end
            StWrHi: begin
                state_d = StWrLo;
            end
            StWrLo: begin
                // Address moves only after the write window so the port stays stable.
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 16'd1;
                state_d = (count_q == 16'd1) ? StAfterLoad : StInstHi;
            end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    state_d = (in_byte == csum_q) ? StCoreRst : StError;
                end
            end
`endif
            StCoreRst: begin
                if (timer_q == TimerWidth'(1)) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StStart;
            end
            StStart: begin
                if (core_running_sync) begin
                    state_d = StRun;
                end else if (timer_q == TimerWidth'(RUN_TIMEOUT - 1)) begin
                    state_d = StError;
                end
            end
            StRun: begin
                if (!core_running_sync) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timer counts cycles spent in the current timed state.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StCoreRst || state_q == StStart) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        ready_d        = 1'b0;
        write_d        = 1'b0;
        core_reset_d   = 1'b0;
        core_running_d = 1'b0;
        busy_d         = 1'b1;
        done_d         = 1'b0;
        error_d        = 1'b0;
        unique case (state_d)
            StIdle:                                 busy_d = 1'b0;
            StDone:    begin busy_d = 1'b0; done_d  = 1'b1; end
            StError:   begin busy_d = 1'b0; error_d = 1'b1; end
            StLenHi, StLenLo, StInstHi, StInstLo:   ready_d = 1'b1;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            StCheck:                                ready_d = 1'b1;
`endif
            StWrHi:                                 write_d = 1'b1;
            StCoreRst:                              core_reset_d = 1'b1;
            StStart:                                core_running_d = 1'b1;
            default:                                busy_d = 1'b1;
        endcase
    end

    // Registered status and strobe outputs.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            out_byte_ready        <= 1'b0;
            out_instruction_write <= 1'b0;
            out_core_reset        <= 1'b0;
            out_core_running      <= 1'b0;
            out_busy              <= 1'b0;
            out_done              <= 1'b0;
            out_error             <= 1'b0;
        end else begin
            out_byte_ready        <= ready_d;
            out_instruction_write <= write_d;
            out_core_reset        <= core_reset_d;
            out_core_running      <= core_running_d;
            out_busy              <= busy_d;
            out_done              <= done_d;
            out_error             <= error_d;
        end
    end

endmodule
